logic_unit_arbiter: RTL
=======================

# logic_unit_arbiter

Shares one 4-bit bitwise logic unit (AND/OR/XOR/XNOR) between two requesters. Requests are arbitrated round-robin, executed in one cycle, and returned through a registered response port with backpressure. The block sits between the core's two operand sources and the 4bitLogic datapath, and is the only agent that drives that datapath.

## Interface
- WIDTH, 4, operand/result width in bits
- CNT_W, 8, grant-counter width (used only with LOGIC_ARB_STATS_EN)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  2  opcode: 00 AND, 01 OR, 10 XOR, 11 XNOR
- req0_a, req0_b  in  WIDTH  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  index of requester that issued the result
- rsp_y  out  WIDTH  result
- gnt0_cnt, gnt1_cnt  out  CNT_W  grants per requester (present only with LOGIC_ARB_STATS_EN)

## Operation
- FSM with two states: IDLE, RESP. Reset state IDLE.
- IDLE: if any reqN_valid, select winner: if only one is valid, that one; if both are valid, the one indicated by pointer prio. Assert winner's reqN_ready (combinational); the other ready stays 0. Handshake = valid & ready.
- On handshake: rsp_y <= op(a,b) of winner, rsp_id <= winner, rsp_valid <= 1, prio <= ~winner, state -> RESP.
- RESP: both readys 0; rsp_valid/rsp_id/rsp_y held stable. When rsp_ready=1: rsp_valid <= 0, state -> IDLE. rsp_y and rsp_id keep their last values.
- No request is accepted in the same cycle that a response is consumed. Peak throughput is one operation per 2 cycles.
- A requester must hold its valid and operands until ready. Dropping valid before a grant is tolerated: no grant is issued and no state changes.
- The bitwise op is applied across all WIDTH bits. XNOR = ~(a^b), full width, with no masking.
- Reset values: rsp_valid 0, rsp_id 0, rsp_y 0, prio 0 (requester 0 favoured), state IDLE, counters 0. Ready outputs evaluate to 0 while rst_n=0.
- Reset asserted in RESP discards the pending result immediately (asynchronous). No response is produced after reset is released.

## Timing
- Latency: handshake at edge N -> rsp_valid=1 and data valid after edge N (visible in cycle N+1).
- rsp_valid falls on the edge where rsp_valid & rsp_ready. The earliest next handshake is the following cycle.
- reqN_ready depends combinationally on both reqN_valid, state and prio. There is no combinational path from rsp_ready to any output.

## Configuration
- LOGIC_ARB_STATS_EN defined: gnt0_cnt/gnt1_cnt ports exist. Each handshake increments the winner's counter. Counters saturate at all-ones and reset to 0.
- Not defined: the ports and counters are absent. Arbitration behaviour is identical.

## Test plan
- Reset: hold rst_n=0 with both valids at 1 -> rsp_valid=0, rsp_y=0000, rsp_id=0, both readys 0. Release -> req0 granted first.
- Single request: req0 XNOR a=1100 b=1010, rsp_ready=1 -> req0_ready=1 in cycle 0, rsp_valid=1 with rsp_id=0, rsp_y=1001 in cycle 1, back to IDLE in cycle 2.
- Contention: both valid continuously; req0 AND 0011,0101 and req1 OR 1111,0000 -> responses alternate id0 y=0001, id1 y=1111, id0, id1. Each requester gets a grant every 4 cycles.
- Backpressure: result XOR 1111^0000 pending, rsp_ready=0 for 3 cycles -> rsp_y=1111 and rsp_id held, both readys 0. Set rsp_ready=1 -> rsp_valid falls next edge.
- Reset mid-RESP: pulse rst_n low while rsp_valid=1 -> rsp_valid drops without a clock edge, no stale response after release, prio back to 0.
- Stats (macro on, CNT_W=2): 5 grants to req1 -> gnt1_cnt reads 1,2,3,3,3 and gnt0_cnt stays 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/XNOR) between two requesters.
// Define LOGIC_ARB_STATS_EN to add the saturating per-requester grant counters gnt0_cnt/gnt1_cnt.
module logic_unit_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
`ifdef LOGIC_ARB_STATS_EN
    output logic [WIDTH-1:0] rsp_y,
    output logic [CNT_W-1:0] gnt0_cnt,
    output logic [CNT_W-1:0] gnt1_cnt
`else
    output logic [WIDTH-1:0] rsp_y
`endif
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t           state, state_nxt;
    logic             prio;
    logic             any_valid;
    logic             win;
    logic             fire;
    logic [1:0]       win_op;
    logic [WIDTH-1:0] win_a, win_b, result;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("logic_unit_arbiter: WIDTH and CNT_W must be at least 1");
    end

    // Contention goes to the pointer; a lone requester always wins.
    assign any_valid = req0_valid | req1_valid;
    assign win       = (req0_valid & req1_valid) ? prio : req1_valid;
    assign win_op    = win ? req1_op : req0_op;
    assign win_a     = win ? req1_a  : req0_a;
    assign win_b     = win ? req1_b  : req0_b;

    always_comb begin
        result = '0;
        case (win_op)
            2'b00:   result = win_a & win_b;
            2'b01:   result = win_a | win_b;
            2'b10:   result = win_a ^ win_b;
            default: result = ~(win_a ^ win_b);
        endcase
    end

    // Readys are gated by rst_n so they read 0 throughout reset.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && any_valid) begin
                    fire       = 1'b1;
                    req0_ready = ~win;
                    req1_ready = win;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                rsp_valid <= 1'b1;
                rsp_id    <= win;
                rsp_y     <= result;
                prio      <= ~win;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else if (fire) begin
            if (!win && gnt0_cnt != '1) gnt0_cnt <= gnt0_cnt + CNT_W'(1);
            if (win && gnt1_cnt != '1)  gnt1_cnt <= gnt1_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
